// File: rtl/amba_reg_pkg.sv
// Shared types and register map for the 8-bit valid/ready register-write bus.
package amba_reg_pkg;

  typedef logic [7:0] addr_t;
  typedef logic [7:0] data_t;

  typedef struct packed {
    addr_t addr;
    data_t data;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  localparam addr_t REG_TPU_CTRL  = 8'h20;
  localparam addr_t REG_TX_SLOT   = 8'h21;
  localparam addr_t REG_RX_SLOT   = 8'h22;
  localparam addr_t REG_TPUINT_B0 = 8'h23;
  localparam addr_t REG_TPUINT_B1 = 8'h24;

endpackage

// File: rtl/amba_cmd_fifo.sv
// Show-ahead command FIFO: head is visible combinationally so the master can load it on pop.
module amba_cmd_fifo
  import amba_reg_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  cmd_t             push_cmd_i,
  input  logic             pop_i,
  output cmd_t             head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  // Full refuses a push even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_cmd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

endmodule

// File: rtl/amba_reg_master.sv
// Register-write bus initiator: queues commands, issues one at a time with a ready timeout,
// an idle gap after each transfer, and done/error reporting.
module amba_reg_master
  import amba_reg_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 255,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [7:0]       cmd_addr_i,
  input  logic [7:0]       cmd_data_i,
  output logic             bus_valid_o,
  input  logic             bus_ready_i,
  output logic [7:0]       bus_addr_o,
  output logic [7:0]       bus_wdata_o,
  output logic             xfer_done_o,
  output logic             xfer_err_o,
  output logic             err_sticky_o,
  output logic [7:0]       err_addr_o,
  input  logic             err_clr_i,
  output logic             busy_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GAP_W = $clog2(GAP + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             valid_q, valid_d;
  addr_t            addr_q, addr_d;
  data_t            wdata_q, wdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  addr_t            err_addr_q, err_addr_d;

  cmd_t             head;
  cmd_t             push_cmd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             timeout_hit;

  assign push_cmd = '{addr: cmd_addr_i, data: cmd_data_i};

  amba_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (cmd_valid_i),
    .push_cmd_i (push_cmd),
    .pop_i      (fifo_pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (level_o)
  );

  // cnt_q counts completed valid cycles; hitting TIMEOUT-1 without ready ends the transfer.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    sticky_d   = err_clr_i ? 1'b0 : sticky_q;
    err_addr_d = err_addr_q;
    fifo_pop   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = head.addr;
          wdata_d  = head.data;
          valid_d  = 1'b1;
          cnt_d    = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus_ready_i) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (timeout_hit) begin
          // A timeout outranks a simultaneous err_clr.
          valid_d    = 1'b0;
          err_d      = 1'b1;
          sticky_d   = 1'b1;
          err_addr_d = addr_q;
          gap_d      = '0;
          state_d    = S_GAP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      gap_q      <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign cmd_ready_o  = !fifo_full;
  assign bus_valid_o  = valid_q;
  assign bus_addr_o   = addr_q;
  assign bus_wdata_o  = wdata_q;
  assign xfer_done_o  = done_q;
  assign xfer_err_o   = err_q;
  assign err_sticky_o = sticky_q;
  assign err_addr_o   = err_addr_q;
  assign busy_o       = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_amba_reg_master.sv
// Randomised scoreboard bench for amba_reg_master: stimulus queues expected transfers,
// a negedge monitor pops and checks every bus transfer and its done/err outcome.
module tb_amba_reg_master;

  localparam int DEPTH   = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 8;
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int NEVER   = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [7:0]       cmd_addr = '0;
  logic [7:0]       cmd_data = '0;
  logic             bus_valid;
  logic             bus_ready = 1'b0;
  logic [7:0]       bus_addr;
  logic [7:0]       bus_wdata;
  logic             xfer_done;
  logic             xfer_err;
  logic             err_sticky;
  logic [7:0]       err_addr;
  logic             err_clr = 1'b0;
  logic             busy;
  logic [LVL_W-1:0] level;

  amba_reg_master #(
    .DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_data_i   (cmd_data),
    .bus_valid_o  (bus_valid),
    .bus_ready_i  (bus_ready),
    .bus_addr_o   (bus_addr),
    .bus_wdata_o  (bus_wdata),
    .xfer_done_o  (xfer_done),
    .xfer_err_o   (xfer_err),
    .err_sticky_o (err_sticky),
    .err_addr_o   (err_addr),
    .err_clr_i    (err_clr),
    .busy_o       (busy),
    .level_o      (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         delay;
  } exp_t;

  exp_t exp_q[$];
  int   dly_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
  endtask

  // Ready responder: a transfer with delay d sees ready in its (d+1)th valid cycle.
  bit r_prev = 1'b0;
  int r_cyc = 0;
  int r_delay = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      r_prev    = 1'b0;
      bus_ready = 1'b0;
    end else begin
      if (bus_valid) begin
        if (!r_prev) begin
          r_delay = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
          r_cyc   = 0;
        end
        bus_ready = (r_cyc == r_delay);
        r_cyc++;
      end else begin
        bus_ready = 1'($urandom_range(0, 1));
      end
      r_prev = bus_valid;
    end
  end

  // Monitor / scoreboard.
  bit   m_prev = 1'b0;
  bit   m_seen = 1'b0;
  int   m_vlen = 0;
  int   m_idle = 0;
  bit   m_done_exp;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_prev = 1'b0;
      m_seen = 1'b0;
      m_idle = 0;
    end else begin
      if (bus_valid && !m_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer_addr", int'(bus_addr), -1);
        end else begin
          cur    = exp_q.pop_front();
          m_vlen = 1;
          chk("xfer_addr", int'(bus_addr), int'(cur.addr));
          chk("xfer_data", int'(bus_wdata), int'(cur.data));
          if (m_seen) chk("idle_between_xfers_ok", int'(m_idle >= GAP + 1), 1);
          m_seen = 1'b1;
        end
      end else if (bus_valid && m_prev) begin
        m_vlen++;
        chk("addr_stable", int'(bus_addr), int'(cur.addr));
        chk("data_stable", int'(bus_wdata), int'(cur.data));
      end
      m_idle = bus_valid ? 0 : m_idle + 1;

      if (m_prev && !bus_valid) begin
        m_done_exp = (cur.delay < TIMEOUT);
        chk("xfer_done", int'(xfer_done), int'(m_done_exp));
        chk("xfer_err", int'(xfer_err), int'(!m_done_exp));
        chk("valid_len", m_vlen, m_done_exp ? cur.delay + 1 : TIMEOUT);
        if (!m_done_exp) begin
          chk("err_addr", int'(err_addr), int'(cur.addr));
          chk("err_sticky_on_err", int'(err_sticky), 1);
        end
      end else begin
        chk("no_stray_pulse", int'({xfer_done, xfer_err}), 0);
      end
      chk("cmd_ready_vs_level", int'(cmd_ready), int'(int'(level) != DEPTH));
      chk("level_le_depth", int'(int'(level) <= DEPTH), 1);
      m_prev = bus_valid;
    end
  end

  // Single-cycle push with a bench-predicted acceptance.
  task automatic push1(input logic [7:0] a, input logic [7:0] d, input int dly, input bit exp_acc);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    chk("push_accept", int'(cmd_ready), int'(exp_acc));
    if (exp_acc) begin
      exp_q.push_back('{addr: a, data: d, delay: dly});
      dly_q.push_back(dly);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Handshaked push: hold the command until the FIFO takes it (bounded).
  task automatic send(input logic [7:0] a, input logic [7:0] d, input int dly);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_within_bound", int'(cmd_ready), 1);
    if (cmd_ready) begin
      exp_q.push_back('{addr: a, data: d, delay: dly});
      dly_q.push_back(dly);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_within_bound", int'(n < 3000), 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("valid_within_bound", int'(bus_valid), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_bus_valid", int'(bus_valid), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_pulses", int'({xfer_done, xfer_err}), 0);
    chk("rst_sticky", int'(err_sticky), 0);
    chk("rst_err_addr", int'(err_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_bus_addr_data", int'({bus_addr, bus_wdata}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single transfer: latency, done pulse, gap, busy release.
    push1(8'h21, 8'hA5, 0, 1'b1);
    chk("t1_valid_not_yet", int'(bus_valid), 0);
    @(negedge clk);
    chk("t1_valid_next_cycle", int'(bus_valid), 1);
    @(negedge clk);
    chk("t1_done_pulse", int'(xfer_done), 1);
    chk("t1_valid_dropped", int'(bus_valid), 0);
    @(negedge clk);
    chk("t1_busy_in_gap", int'(busy), 1);
    @(negedge clk);
    chk("t1_busy_falls", int'(busy), 0);
    chk("t1_addr_held", int'(bus_addr), 8'h21);
    drain();

    // Register map back-to-back with random ready delays.
    for (int i = 0; i < 5; i++) send(8'(8'h20 + i), 8'($urandom), int'($urandom_range(0, 5)));
    drain();

    // Fill while the first transfer is stuck waiting for ready.
    push1(8'h30, 8'h01, NEVER, 1'b1);
    for (int i = 0; i < DEPTH; i++) push1(8'(8'h31 + i), 8'(8'h10 + i), 0, 1'b1);
    chk("t3_level_full", int'(level), DEPTH);
    chk("t3_cmd_ready_low", int'(cmd_ready), 0);
    push1(8'h3F, 8'hEE, 0, 1'b0);
    chk("t3_level_after_refused", int'(level), DEPTH);
    drain();

    // Timeout on 0x23, then ready arriving in the last allowed cycle.
    send(8'h23, 8'h5A, NEVER);
    send(8'h24, 8'h11, TIMEOUT - 1);
    drain();
    chk("t4_sticky", int'(err_sticky), 1);
    chk("t4_err_addr", int'(err_addr), 8'h23);

    // Random mix, including timeouts and arbitrary addresses.
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'($urandom), 8'($urandom), int'($urandom_range(0, 10)));
    end
    drain();

    // err_clr alone clears; err_clr coincident with a timeout loses.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t5_clr_alone", int'(err_sticky), 0);
    send(8'h22, 8'h77, NEVER);
    wait_valid();
    repeat (TIMEOUT - 1) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t5_timeout_beats_clr", int'(err_sticky), 1);
    chk("t5_err_pulse", int'(xfer_err), 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t5_clr_after", int'(err_sticky), 0);
    drain();

    // Asynchronous reset in the middle of a transfer.
    send(8'h23, 8'h44, NEVER);
    send(8'h20, 8'h02, 0);
    wait_valid();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid_drops", int'(bus_valid), 0);
    chk("t6_level_zero", int'(level), 0);
    chk("t6_cmd_ready", int'(cmd_ready), 1);
    chk("t6_busy", int'(busy), 0);
    chk("t6_pulses", int'({xfer_done, xfer_err}), 0);
    chk("t6_err_addr", int'(err_addr), 0);
    exp_q.delete();
    dly_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h24, 8'h99, 1);
    send(8'h21, 8'h3C, 0);
    drain();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
